// File: rtl/datapath_pkg.sv
// Shared widths, ALU opcodes and bus-source indices for the single-bus CPU datapath.
package datapath_pkg;

    localparam int WORD_W   = 32;
    localparam int NUM_REGS = 16;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // Bus sources; a lower index wins when several drive requests are raised.
    localparam int SRC_R0     = 0;
    localparam int SRC_HI     = 16;
    localparam int SRC_LO     = 17;
    localparam int SRC_ZHI    = 18;
    localparam int SRC_ZLO    = 19;
    localparam int SRC_PC     = 20;
    localparam int SRC_MDR    = 21;
    localparam int SRC_INPORT = 22;
    localparam int NUM_SRC    = 23;
    localparam int SRC_W      = 5;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus; 64-bit result feeds Z.
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [WORD_W-1:0]   a,
    input  logic [WORD_W-1:0]   b,
    input  logic [4:0]          opcode,
    output logic [2*WORD_W-1:0] result
);

    logic [4:0]              shamt;
    logic [2*WORD_W-1:0]     rot;
    logic signed [WORD_W-1:0] quo;
    logic signed [WORD_W-1:0] rem;

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        shamt  = b[4:0];
        rot    = '0;
        quo    = $signed(a) / $signed(b);
        rem    = $signed(a) % $signed(b);
        result = '0;
        case (opcode)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: result[WORD_W-1:0] = a + b;
            OP_SUB:          result[WORD_W-1:0] = a - b;
            OP_AND, OP_ANDI: result[WORD_W-1:0] = a & b;
            OP_OR, OP_ORI:   result[WORD_W-1:0] = a | b;
            OP_SHR:          result[WORD_W-1:0] = a >> shamt;
            OP_SHRA:         result[WORD_W-1:0] = $signed(a) >>> shamt;
            OP_SHL:          result[WORD_W-1:0] = a << shamt;
            OP_ROR: begin
                rot = {a, a} >> shamt;
                result[WORD_W-1:0] = rot[WORD_W-1:0];
            end
            OP_ROL: begin
                rot = {a, a} << shamt;
                result[WORD_W-1:0] = rot[2*WORD_W-1:WORD_W];
            end
            // Sign-extended operands make the truncated unsigned product the signed one.
            OP_MUL: result = {{WORD_W{a[WORD_W-1]}}, a} * {{WORD_W{b[WORD_W-1]}}, b};
            OP_DIV: begin
                if (b == '0) result = {a, {WORD_W{1'b0}}};
                else         result = {rem, quo};
            end
            OP_NEG:  result[WORD_W-1:0] = -b;
            OP_NOT:  result[WORD_W-1:0] = ~b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit datapath: register file, special registers, priority bus mux and ALU.
module datapath
    import datapath_pkg::*;
(
    input logic                clock,
    input logic                clear,
    input logic [WORD_W-1:0]   Mdatain,
    input logic                read,
    input logic                inc_pc,
    input logic [NUM_REGS-1:0] r_in,
    input logic [NUM_REGS-1:0] r_out,
    input logic                pc_in,
    input logic                z_in,
    input logic                mdr_in,
    input logic                mar_in,
    input logic                y_in,
    input logic                hi_in,
    input logic                lo_in,
    input logic                pc_out,
    input logic                zhigh_out,
    input logic                zlow_out,
    input logic                hi_out,
    input logic                lo_out,
    input logic                mdr_out,
    input logic                inport_out,
    input logic [4:0]          opcode
);

    logic [WORD_W-1:0]   r_q [NUM_REGS];
    logic [WORD_W-1:0]   r_d [NUM_REGS];
    logic [WORD_W-1:0]   pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
    logic [WORD_W-1:0]   y_q, y_d, hi_q, hi_d, lo_q, lo_d, inport_q, inport_d;
    logic [2*WORD_W-1:0] z_q, z_d, alu_result;

    logic [NUM_SRC-1:0]  bus_req;
    logic [WORD_W-1:0]   src_data [NUM_SRC];
    logic [SRC_W-1:0]    bus_sel;
    logic                bus_hit;
    logic [WORD_W-1:0]   bus;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regfile
        assign bus_req[SRC_R0 + i]  = r_out[i];
        assign src_data[SRC_R0 + i] = r_q[i];
        assign r_d[i]               = r_in[i] ? bus : r_q[i];
    end

    assign bus_req[SRC_HI]     = hi_out;
    assign bus_req[SRC_LO]     = lo_out;
    assign bus_req[SRC_ZHI]    = zhigh_out;
    assign bus_req[SRC_ZLO]    = zlow_out;
    assign bus_req[SRC_PC]     = pc_out;
    assign bus_req[SRC_MDR]    = mdr_out;
    assign bus_req[SRC_INPORT] = inport_out;

    assign src_data[SRC_HI]     = hi_q;
    assign src_data[SRC_LO]     = lo_q;
    assign src_data[SRC_ZHI]    = z_q[2*WORD_W-1:WORD_W];
    assign src_data[SRC_ZLO]    = z_q[WORD_W-1:0];
    assign src_data[SRC_PC]     = pc_q;
    assign src_data[SRC_MDR]    = mdr_q;
    assign src_data[SRC_INPORT] = inport_q;

    // Scan from the lowest-priority source upward so the last hit is the winner.
    always_comb begin
        bus_sel = '0;
        bus_hit = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (bus_req[i]) begin
                bus_sel = SRC_W'(i);
                bus_hit = 1'b1;
            end
        end
    end

    assign bus = bus_hit ? src_data[bus_sel] : '0;

    datapath_alu u_alu (
        .a      (y_q),
        .b      (bus),
        .opcode (opcode),
        .result (alu_result)
    );

    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        mar_d    = mar_q;
        mdr_d    = mdr_q;
        y_d      = y_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        z_d      = z_q;
        inport_d = '0;
        if (pc_in)  pc_d  = inc_pc ? pc_q + 32'd1 : bus;
        if (mar_in) mar_d = bus;
        if (mdr_in) mdr_d = read ? Mdatain : bus;
        if (y_in)   y_d   = bus;
        if (hi_in)  hi_d  = bus;
        if (lo_in)  lo_d  = bus;
        if (z_in)   z_d   = alu_result;
    end

    // NOTE: non-blocking updates let a register drive the bus and load from it on the same edge.
    // NOTE: the register-file array is cleared too, since clear must zero every register.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) r_q[i] <= '0;
            pc_q     <= '0;
            ir_q     <= '0;
            mar_q    <= '0;
            mdr_q    <= '0;
            y_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            z_q      <= '0;
            inport_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) r_q[i] <= r_d[i];
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            y_q      <= y_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            z_q      <= z_d;
            inport_q <= inport_d;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench: stimulus pushes expected register/bus values, a negedge monitor compares them.
module tb_datapath;
    import datapath_pkg::*;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] Mdatain;
    logic        read, inc_pc;
    logic [15:0] r_in, r_out;
    logic        pc_in, z_in, mdr_in, mar_in, y_in, hi_in, lo_in;
    logic        pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out, inport_out;
    logic [4:0]  opcode;

    datapath dut (
        .clock(clock), .clear(clear), .Mdatain(Mdatain), .read(read), .inc_pc(inc_pc),
        .r_in(r_in), .r_out(r_out), .pc_in(pc_in), .z_in(z_in), .mdr_in(mdr_in),
        .mar_in(mar_in), .y_in(y_in), .hi_in(hi_in), .lo_in(lo_in), .pc_out(pc_out),
        .zhigh_out(zhigh_out), .zlow_out(zlow_out), .hi_out(hi_out), .lo_out(lo_out),
        .mdr_out(mdr_out), .inport_out(inport_out), .opcode(opcode)
    );

    always #5 clock = ~clock;

    localparam int T_PC = 16, T_MAR = 17, T_MDR = 18, T_Y = 19, T_ZLO = 20, T_ZHI = 21;
    localparam int T_HI = 22, T_LO = 23, T_IR = 24, T_BUS = 25, T_LAST_REG = 24;

    typedef struct {
        string       name;
        int          tgt;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic [31:0] mon_act;
    int n_checks = 0;
    int n_errors = 0;

    // Reference machine state.
    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo;
    logic [63:0] m_z;

    function automatic logic [31:0] observe(int tgt);
        if (tgt < 16) return dut.r_q[tgt];
        case (tgt)
            T_PC:    return dut.pc_q;
            T_MAR:   return dut.mar_q;
            T_MDR:   return dut.mdr_q;
            T_Y:     return dut.y_q;
            T_ZLO:   return dut.z_q[31:0];
            T_ZHI:   return dut.z_q[63:32];
            T_HI:    return dut.hi_q;
            T_LO:    return dut.lo_q;
            T_IR:    return dut.ir_q;
            default: return dut.bus;
        endcase
    endfunction

    function automatic logic [31:0] model_value(int tgt);
        if (tgt < 16) return m_r[tgt];
        case (tgt)
            T_PC:    return m_pc;
            T_MAR:   return m_mar;
            T_MDR:   return m_mdr;
            T_Y:     return m_y;
            T_ZLO:   return m_z[31:0];
            T_ZHI:   return m_z[63:32];
            T_HI:    return m_hi;
            T_LO:    return m_lo;
            default: return m_ir;
        endcase
    endfunction

    function automatic string tgt_name(int tgt);
        string names [9] = '{"PC", "MAR", "MDR", "Y", "ZLO", "ZHI", "HI", "LO", "IR"};
        if (tgt < 16) return $sformatf("R%0d", tgt);
        return names[tgt - 16];
    endfunction

    // Bus source chosen by walking the priority list in order.
    function automatic logic [31:0] model_bus();
        for (int i = 0; i < 16; i++) if (r_out[i]) return m_r[i];
        if (hi_out)    return m_hi;
        if (lo_out)    return m_lo;
        if (zhigh_out) return m_z[63:32];
        if (zlow_out)  return m_z[31:0];
        if (pc_out)    return m_pc;
        if (mdr_out)   return m_mdr;
        return 32'h0;
    endfunction

    function automatic logic [63:0] model_alu(logic [31:0] a, logic [31:0] b, logic [4:0] op);
        int          sa, sb, n, q, r;
        longint      p;
        logic [31:0] w;
        sa = a;
        sb = b;
        n  = int'(b % 32);
        w  = a;
        case (op)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: return {32'h0, a + b};
            OP_SUB:          return {32'h0, a - b};
            OP_AND, OP_ANDI: return {32'h0, a & b};
            OP_OR, OP_ORI:   return {32'h0, a | b};
            OP_SHR:          return {32'h0, a >> n};
            OP_SHRA:         return {32'h0, 32'(sa >>> n)};
            OP_SHL:          return {32'h0, a << n};
            OP_ROR: begin
                repeat (n) w = {w[0], w[31:1]};
                return {32'h0, w};
            end
            OP_ROL: begin
                repeat (n) w = {w[30:0], w[31]};
                return {32'h0, w};
            end
            OP_MUL: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            OP_DIV: begin
                if (sb == 0) return {a, 32'h0};
                q = sa / sb;
                r = sa - q * sb;
                return {r, q};
            end
            OP_NEG:  return {32'h0, 32'h0 - b};
            OP_NOT:  return {32'h0, ~b};
            default: return 64'h0;
        endcase
    endfunction

    task automatic expect_now(input string name, input int tgt, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.tgt  = tgt;
        e.exp  = val;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        clear = 0; Mdatain = '0; read = 0; inc_pc = 0; r_in = '0; r_out = '0;
        pc_in = 0; z_in = 0; mdr_in = 0; mar_in = 0; y_in = 0; hi_in = 0; lo_in = 0;
        pc_out = 0; zhigh_out = 0; zlow_out = 0; hi_out = 0; lo_out = 0; mdr_out = 0;
        inport_out = 0; opcode = '0;
    endtask

    // One transfer: predict the bus, take the edge, advance the model, expect full state.
    task automatic tick();
        logic [31:0] b, old_pc;
        logic [63:0] zres;
        b = model_bus();
        if (opcode == OP_DIV && m_y == 32'h8000_0000 && b == 32'hFFFF_FFFF) opcode = OP_ADD;
        zres = model_alu(m_y, b, opcode);
        expect_now("bus", T_BUS, b);
        @(posedge clock);
        #1;
        if (clear) begin
            for (int i = 0; i < 16; i++) m_r[i] = '0;
            m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0; m_y = '0; m_hi = '0; m_lo = '0;
            m_z = '0;
        end else begin
            old_pc = m_pc;
            for (int i = 0; i < 16; i++) if (r_in[i]) m_r[i] = b;
            if (pc_in)  m_pc  = inc_pc ? old_pc + 32'd1 : b;
            if (mar_in) m_mar = b;
            if (mdr_in) m_mdr = read ? Mdatain : b;
            if (y_in)   m_y   = b;
            if (hi_in)  m_hi  = b;
            if (lo_in)  m_lo  = b;
            if (z_in)   m_z   = zres;
        end
        for (int t = 0; t <= T_LAST_REG; t++) expect_now(tgt_name(t), t, model_value(t));
        idle();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; read = 1; mdr_in = 1;
        tick();
    endtask

    task automatic mdr_to_y(input logic [31:0] v);
        load_mdr(v);
        mdr_out = 1; y_in = 1;
        tick();
    endtask

    task automatic alu_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        mdr_to_y(a);
        load_mdr(b);
        mdr_out = 1; opcode = op; z_in = 1;
        tick();
    endtask

    always @(negedge clock) begin
        while (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_act = observe(mon_e.tgt);
            n_checks++;
            if (mon_act !== mon_e.exp) begin
                n_errors++;
                $display("FAIL %s: actual=%08h required=%08h", mon_e.name, mon_act, mon_e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0; m_y = '0; m_hi = '0; m_lo = '0; m_z = '0;
        idle();
        clear = 1;
        @(posedge clock);
        #1;
        clear = 1;
        tick();
        expect_now("rst_pc", T_PC, 32'h0);
        expect_now("rst_r15", 15, 32'h0);
        expect_now("rst_zhi", T_ZHI, 32'h0);

        // R1 = R2 AND R3
        load_mdr(32'h12);
        mdr_out = 1; r_in = 16'h0004; tick();
        load_mdr(32'h14);
        mdr_out = 1; r_in = 16'h0008; tick();
        r_out = 16'h0004; y_in = 1; tick();
        r_out = 16'h0008; opcode = OP_AND; z_in = 1; tick();
        zlow_out = 1; r_in = 16'h0002; tick();
        expect_now("and_r1", 1, 32'h0000_0010);
        expect_now("and_zhi", T_ZHI, 32'h0);

        // Priority: R3 beats MDR; nothing requested gives 0.
        load_mdr(32'hDEAD_BEEF);
        r_out = 16'h0008; mdr_out = 1;
        expect_now("prio_bus", T_BUS, 32'h14);
        tick();
        expect_now("idle_bus", T_BUS, 32'h0);
        tick();

        // PC increment
        pc_out = 1; mar_in = 1; tick();
        pc_in = 1; inc_pc = 1; tick();
        expect_now("pc_mar", T_MAR, 32'h0);
        expect_now("pc_inc", T_PC, 32'h1);
        inc_pc = 1; tick();
        expect_now("pc_hold", T_PC, 32'h1);

        alu_op(32'hFFFF_FFFE, 32'h3, OP_MUL);
        expect_now("mul_zhi", T_ZHI, 32'hFFFF_FFFF);
        expect_now("mul_zlo", T_ZLO, 32'hFFFF_FFFA);
        zhigh_out = 1; hi_in = 1; tick();
        zlow_out = 1; lo_in = 1; tick();
        expect_now("mul_hi", T_HI, 32'hFFFF_FFFF);
        expect_now("mul_lo", T_LO, 32'hFFFF_FFFA);

        alu_op(32'hFFFF_FFF9, 32'h2, OP_DIV);
        expect_now("div_quo", T_ZLO, 32'hFFFF_FFFD);
        expect_now("div_rem", T_ZHI, 32'hFFFF_FFFF);
        alu_op(32'h5, 32'h0, OP_DIV);
        expect_now("div0_quo", T_ZLO, 32'h0);
        expect_now("div0_rem", T_ZHI, 32'h5);

        alu_op(32'h8000_0001, 32'h1, OP_SHR);
        expect_now("shr", T_ZLO, 32'h4000_0000);
        alu_op(32'h8000_0001, 32'h1, OP_SHRA);
        expect_now("shra", T_ZLO, 32'hC000_0000);
        alu_op(32'h8000_0001, 32'h1, OP_ROL);
        expect_now("rol", T_ZLO, 32'h0000_0003);
        alu_op(32'h8000_0001, 32'd33, OP_ROR);
        expect_now("ror33", T_ZLO, 32'hC000_0000);

        for (int k = 0; k < 300; k++) begin
            clear      = ($urandom_range(0, 40) == 0);
            Mdatain    = $urandom;
            read       = 1'($urandom_range(0, 1));
            inc_pc     = 1'($urandom_range(0, 1));
            r_in       = 16'($urandom) & 16'($urandom);
            r_out      = ($urandom_range(0, 1) == 1) ? (16'd1 << $urandom_range(0, 15)) : 16'd0;
            pc_in      = ($urandom_range(0, 3) == 0);
            z_in       = ($urandom_range(0, 1) == 0);
            mdr_in     = ($urandom_range(0, 1) == 0);
            mar_in     = ($urandom_range(0, 3) == 0);
            y_in       = ($urandom_range(0, 2) == 0);
            hi_in      = ($urandom_range(0, 3) == 0);
            lo_in      = ($urandom_range(0, 3) == 0);
            pc_out     = ($urandom_range(0, 5) == 0);
            zhigh_out  = ($urandom_range(0, 5) == 0);
            zlow_out   = ($urandom_range(0, 5) == 0);
            hi_out     = ($urandom_range(0, 5) == 0);
            lo_out     = ($urandom_range(0, 5) == 0);
            mdr_out    = ($urandom_range(0, 2) == 0);
            inport_out = ($urandom_range(0, 5) == 0);
            opcode     = 5'($urandom_range(0, 31));
            tick();
        end

        // clear wins over every load enable
        clear = 1; r_in = 16'hFFFF; r_out = 16'h0002; pc_in = 1; z_in = 1; mdr_in = 1;
        mar_in = 1; y_in = 1; hi_in = 1; lo_in = 1; opcode = OP_NOT;
        tick();
        expect_now("clr_pc", T_PC, 32'h0);
        expect_now("clr_r1", 1, 32'h0);
        expect_now("clr_zlo", T_ZLO, 32'h0);
        expect_now("clr_y", T_Y, 32'h0);

        repeat (2) @(negedge clock);
        #1;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: actual=%0d pending required=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
